// File: rtl/vga_sync_receiver.sv
// vga_sync_receiver
// Recovers the pixel position of an incoming VGA stream from its hsync/vsync
// pair. The timing must stay clean for several frames before lock is declared.
// The block reports timing errors seen while locked and a per-frame checksum
// of the captured active pixels.
module vga_sync_receiver #(
  parameter int H_TOTAL      = 800,
  parameter int H_ACTIVE     = 640,
  parameter int H_SYNC_START = 656,
  parameter int H_SYNC_W     = 96,
  parameter int V_TOTAL      = 525,
  parameter int V_ACTIVE     = 480,
  parameter int V_SYNC_START = 490,
  parameter int V_SYNC_W     = 2,
  parameter int LOCK_FRAMES  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [5:0]  rgb_in,
  output logic [9:0]  hpos,
  output logic [9:0]  vpos,
  output logic        display_on,
  output logic [5:0]  rgb_out,
  output logic        locked,
  output logic [7:0]  err_count,
  output logic [15:0] frame_sum,
  output logic        frame_sum_valid
);

  localparam int TO_LIMIT  = 2 * H_TOTAL;
  localparam int TO_W      = $clog2(TO_LIMIT + 1);
  localparam int SYNC_BITS = 8;

  localparam logic [9:0]      H_LAST      = 10'(H_TOTAL - 1);
  localparam logic [9:0]      H_ACT       = 10'(H_ACTIVE);
  localparam logic [9:0]      H_FALL_POS  = 10'(H_SYNC_START);
  localparam logic [9:0]      H_RISE_POS  = 10'(H_SYNC_START + H_SYNC_W);
  localparam logic [9:0]      V_LAST      = 10'(V_TOTAL - 1);
  localparam logic [9:0]      V_ACT       = 10'(V_ACTIVE);
  localparam logic [9:0]      V_FALL_POS  = 10'(V_SYNC_START);
  localparam logic [9:0]      V_RISE_POS  = 10'(V_SYNC_START + V_SYNC_W);
  localparam logic [TO_W-1:0] TO_LAST     = TO_W'(TO_LIMIT - 1);
  localparam logic [7:0]      GOOD_TARGET = 8'(LOCK_FRAMES);
  // Bit order of the capture bus is {hsync, vsync, rgb[5:0]}; syncs idle high.
  localparam logic [SYNC_BITS-1:0] SYNC_IDLE = 8'hC0;

  typedef enum logic [1:0] {
    SEARCH,
    VERIFY,
    LOCKED
  } state_t;

  // ---------------------------------------------------------------------
  // Two-stage input capture, one flop pair per bit
  // ---------------------------------------------------------------------
  logic [SYNC_BITS-1:0] sync_raw;
  logic [SYNC_BITS-1:0] s2_bus;
  logic [1:0]           s1_sync;

  assign sync_raw = {hsync_in, vsync_in, rgb_in};

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_BITS; gi++) begin : g_sync
      logic s1_reg;
      logic s2_reg;

      // Shift one input bit through s1 then s2; reset to idle so no edge appears at release
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s1_reg <= SYNC_IDLE[gi];
          s2_reg <= SYNC_IDLE[gi];
        end else begin
          s1_reg <= sync_raw[gi];
          s2_reg <= s1_reg;
        end
      end

      assign s2_bus[gi] = s2_reg;

      // Only the sync bits need their first stage for edge detection
      if (gi >= SYNC_BITS - 2) begin : g_edge_tap
        assign s1_sync[gi-(SYNC_BITS-2)] = s1_reg;
      end
    end
  endgenerate

  logic       hs_s1;
  logic       hs_s2;
  logic       vs_s1;
  logic       vs_s2;
  logic [5:0] rgb_s2;

  assign hs_s1  = s1_sync[1];
  assign vs_s1  = s1_sync[0];
  assign hs_s2  = s2_bus[7];
  assign vs_s2  = s2_bus[6];
  assign rgb_s2 = s2_bus[5:0];

  logic hs_fall;
  logic hs_rise;
  logic vs_fall;
  logic vs_rise;

  assign hs_fall = hs_s2 & ~hs_s1;
  assign hs_rise = ~hs_s2 & hs_s1;
  assign vs_fall = vs_s2 & ~vs_s1;
  assign vs_rise = ~vs_s2 & vs_s1;

  // ---------------------------------------------------------------------
  // Position counters, edge checks and hsync watchdog
  // ---------------------------------------------------------------------
  logic [9:0]      h_cnt_reg;
  logic [9:0]      v_cnt_reg;
  logic [TO_W-1:0] to_cnt_reg;
  logic [9:0]      h_cnt_next;
  logic [9:0]      v_cnt_next;
  logic [TO_W-1:0] to_cnt_next;
  logic [9:0]      h_inc;
  logic [9:0]      v_inc;
  logic            h_wrap;
  logic            err_to;
  logic            timing_err;

  // Free-running next positions; edges are checked against the position the
  // incoming pixel would get from free-running, then the counter is reloaded.
  always_comb begin
    h_inc       = (h_cnt_reg == H_LAST) ? 10'd0 : h_cnt_reg + 10'd1;
    h_wrap      = (h_cnt_reg == H_LAST) & ~hs_fall;
    v_inc       = v_cnt_reg;
    if (h_wrap) begin
      v_inc = (v_cnt_reg == V_LAST) ? 10'd0 : v_cnt_reg + 10'd1;
    end
    h_cnt_next  = hs_fall ? H_FALL_POS : h_inc;
    v_cnt_next  = vs_fall ? V_FALL_POS : v_inc;
    err_to      = ~hs_fall & (to_cnt_reg == TO_LAST);
    to_cnt_next = (hs_fall | err_to) ? '0 : to_cnt_reg + TO_W'(1);
    timing_err  = (hs_fall & (h_inc != H_FALL_POS)) |
                  (hs_rise & (h_inc != H_RISE_POS)) |
                  (vs_fall & (v_inc != V_FALL_POS)) |
                  (vs_rise & (v_inc != V_RISE_POS)) |
                  err_to;
  end

  // Register the position counters and the watchdog
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_reg  <= '0;
      v_cnt_reg  <= '0;
      to_cnt_reg <= '0;
    end else begin
      h_cnt_reg  <= h_cnt_next;
      v_cnt_reg  <= v_cnt_next;
      to_cnt_reg <= to_cnt_next;
    end
  end

  // ---------------------------------------------------------------------
  // Lock FSM, error counter and frame checksum
  // ---------------------------------------------------------------------
  state_t      state_reg;
  logic [7:0]  good_reg;
  logic        locked_reg;
  logic [7:0]  err_count_reg;
  logic [15:0] accum_reg;
  logic [15:0] frame_sum_reg;
  logic        frame_valid_reg;

  assign display_on = locked_reg & (h_cnt_reg < H_ACT) & (v_cnt_reg < V_ACT);
  assign rgb_out    = display_on ? rgb_s2 : 6'd0;

  // Qualify timing frame by frame, and publish a checksum only for frames fully seen while locked
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= SEARCH;
      good_reg        <= '0;
      locked_reg      <= 1'b0;
      err_count_reg   <= '0;
      accum_reg       <= '0;
      frame_sum_reg   <= '0;
      frame_valid_reg <= 1'b0;
    end else begin
      frame_valid_reg <= 1'b0;

      if (display_on) begin
        accum_reg <= accum_reg + {10'd0, rgb_out};
      end

      if (vs_fall) begin
        accum_reg <= '0;
        if ((state_reg == LOCKED) && !timing_err) begin
          frame_sum_reg   <= accum_reg;
          frame_valid_reg <= 1'b1;
        end
      end

      case (state_reg)
        SEARCH: begin
          if (vs_fall) begin
            state_reg <= VERIFY;
            good_reg  <= '0;
          end
        end
        VERIFY: begin
          if (timing_err) begin
            state_reg <= SEARCH;
          end else if (vs_fall) begin
            good_reg <= good_reg + 8'd1;
            if (good_reg + 8'd1 == GOOD_TARGET) begin
              state_reg  <= LOCKED;
              locked_reg <= 1'b1;
            end
          end
        end
        LOCKED: begin
          if (timing_err) begin
            state_reg  <= SEARCH;
            locked_reg <= 1'b0;
            if (err_count_reg != 8'hFF) begin
              err_count_reg <= err_count_reg + 8'd1;
            end
          end
        end
        default: begin
          state_reg  <= SEARCH;
          locked_reg <= 1'b0;
        end
      endcase
    end
  end

  assign hpos            = h_cnt_reg;
  assign vpos            = v_cnt_reg;
  assign locked          = locked_reg;
  assign err_count       = err_count_reg;
  assign frame_sum       = frame_sum_reg;
  assign frame_sum_valid = frame_valid_reg;

endmodule
